// File: rtl/plab4_net_tdm_output_sched_if.sv
// Shared-output-port bundle: per-domain requests/grants, downstream ready,
// and the crossbar/ownership indications.
interface plab4_net_tdm_output_sched_if;
  logic [2:0] reqs_d0;
  logic [2:0] reqs_d1;
  logic       out_rdy;
  logic [2:0] grants_d0;
  logic [2:0] grants_d1;
  logic       out_val;
  logic [1:0] xbar_sel;
  logic       cur_domain;

  modport master (
    output reqs_d0, reqs_d1, out_rdy,
    input  grants_d0, grants_d1, out_val, xbar_sel, cur_domain
  );

  modport slave (
    input  reqs_d0, reqs_d1, out_rdy,
    output grants_d0, grants_d1, out_val, xbar_sel, cur_domain
  );
endinterface

// File: rtl/plab4_net_tdm_output_sched.sv
// Time-division output scheduler: two domains alternate ownership of one output
// port in fixed slots separated by dead (drain) intervals; round robin within a domain.
//
// state | meaning
// SLOT0 | domain 0 owns the port, grants allowed to domain 0
// DEAD0 | domain 0 drain interval, no grants
// SLOT1 | domain 1 owns the port, grants allowed to domain 1
// DEAD1 | domain 1 drain interval, no grants
module plab4_net_tdm_output_sched #(
  parameter int unsigned p_slot_len = 8,
  parameter int unsigned p_dead_len = 2
) (
  input logic                         clk,
  input logic                         reset,
  plab4_net_tdm_output_sched_if.slave port
);

  typedef enum logic [1:0] {SLOT0, DEAD0, SLOT1, DEAD1} state_t;

  localparam logic [7:0] SLOT_LEN = 8'(p_slot_len);
  localparam logic [7:0] DEAD_LEN = 8'(p_dead_len);

  state_t     state;
  logic [7:0] cnt;
  logic [2:0] ptr_d0;
  logic [2:0] ptr_d1;
  logic       dom_q;
  logic [2:0] grant_d0_c;
  logic [2:0] grant_d1_c;
  logic [2:0] grant_act;

  // Rotate so the pointer position sits at bit 0, fixed-priority pick, rotate back.
  function automatic logic [2:0] rr_pick(input logic [2:0] reqs, input logic [2:0] ptr);
    logic [2:0] rot;
    logic [2:0] pick;
    logic [2:0] g;
    case (ptr)
      3'b010:  rot = {reqs[0], reqs[2], reqs[1]};
      3'b100:  rot = {reqs[1], reqs[0], reqs[2]};
      default: rot = reqs;
    endcase
    if (rot[0])      pick = 3'b001;
    else if (rot[1]) pick = 3'b010;
    else if (rot[2]) pick = 3'b100;
    else             pick = 3'b000;
    case (ptr)
      3'b010:  g = {pick[1], pick[0], pick[2]};
      3'b100:  g = {pick[0], pick[2], pick[1]};
      default: g = pick;
    endcase
    return g;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= SLOT0;
      cnt    <= SLOT_LEN;
      ptr_d0 <= 3'b001;
      ptr_d1 <= 3'b001;
      dom_q  <= 1'b0;
    end else begin
      if (cnt == 8'd1) begin
        case (state)
          SLOT0: begin state <= DEAD0; cnt <= DEAD_LEN; end
          DEAD0: begin state <= SLOT1; cnt <= SLOT_LEN; dom_q <= 1'b1; end
          SLOT1: begin state <= DEAD1; cnt <= DEAD_LEN; end
          default: begin state <= SLOT0; cnt <= SLOT_LEN; dom_q <= 1'b0; end
        endcase
      end else begin
        cnt <= cnt - 8'd1;
      end
      // Next search starts just past the winner.
      if (|grant_d0_c) ptr_d0 <= {grant_d0_c[1:0], grant_d0_c[2]};
      if (|grant_d1_c) ptr_d1 <= {grant_d1_c[1:0], grant_d1_c[2]};
    end
  end

  always_comb begin
    grant_d0_c = 3'b000;
    grant_d1_c = 3'b000;
    if (!reset && port.out_rdy) begin
      if (state == SLOT0) grant_d0_c = rr_pick(port.reqs_d0, ptr_d0);
      if (state == SLOT1) grant_d1_c = rr_pick(port.reqs_d1, ptr_d1);
    end
  end

  assign grant_act       = dom_q ? grant_d1_c : grant_d0_c;
  assign port.grants_d0  = grant_d0_c;
  assign port.grants_d1  = grant_d1_c;
  assign port.out_val    = (|grant_d0_c) | (|grant_d1_c);
  assign port.xbar_sel   = (grant_act == 3'b001) ? 2'd0 :
                           (grant_act == 3'b010) ? 2'd1 : 2'd2;
  assign port.cur_domain = dom_q & ~reset;

endmodule

// File: tb/tb_plab4_net_tdm_output_sched.sv
// Scoreboard bench: default-parameter and minimum-length instances checked every
// cycle against a slot-arithmetic reference model.
module tb_plab4_net_tdm_output_sched;

  typedef struct packed {
    logic [2:0] g0;
    logic [2:0] g1;
    logic       v;
    logic [1:0] xs;
    logic       cd;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  plab4_net_tdm_output_sched_if bus_a ();
  plab4_net_tdm_output_sched_if bus_b ();

  plab4_net_tdm_output_sched #(.p_slot_len(8), .p_dead_len(2)) dut_a (
    .clk(clk), .reset(rst), .port(bus_a.slave));
  plab4_net_tdm_output_sched #(.p_slot_len(1), .p_dead_len(1)) dut_b (
    .clk(clk), .reset(rst), .port(bus_b.slave));

  int   n_checks = 0;
  int   n_fails  = 0;
  exp_t q_a[$];
  exp_t q_b[$];
  bit   stim_done = 0;

  int slot_m[2] = '{8, 1};
  int dead_m[2] = '{2, 1};
  int t_m[2];
  int ptr_m[2][2];   // [instance][domain] -> index 0..2 of highest priority

  // Position within the 2*(slot+dead) period decides owner and whether grants are open.
  function automatic exp_t model(input int i, input logic [2:0] r0, input logic [2:0] r1,
                                 input logic rdy, input logic rs);
    exp_t e;
    int per, ph, dom, off, win;
    logic [2:0] r, g;
    e = '{g0: 3'b000, g1: 3'b000, v: 1'b0, xs: 2'd2, cd: 1'b0};
    if (rs) begin
      t_m[i] = 0;
      ptr_m[i][0] = 0;
      ptr_m[i][1] = 0;
      return e;
    end
    per = slot_m[i] + dead_m[i];
    ph  = t_m[i] % (2 * per);
    dom = (ph >= per) ? 1 : 0;
    off = ph % per;
    r   = (dom == 1) ? r1 : r0;
    g   = 3'b000;
    win = -1;
    if (off < slot_m[i] && rdy) begin
      for (int k = 0; k < 3; k++) begin
        int idx;
        idx = (ptr_m[i][dom] + k) % 3;
        if (win < 0 && r[idx]) win = idx;
      end
    end
    if (win >= 0) begin
      g[win] = 1'b1;
      ptr_m[i][dom] = (win + 1) % 3;
    end
    e.cd = (dom == 1);
    if (dom == 1) e.g1 = g; else e.g0 = g;
    e.v  = (win >= 0);
    e.xs = (win == 0) ? 2'd0 : (win == 1) ? 2'd1 : 2'd2;
    t_m[i] = t_m[i] + 1;
    return e;
  endfunction

  // Called 1 time unit after a rising edge: drive, predict, advance to next edge.
  task automatic step(input logic [2:0] r0, input logic [2:0] r1, input logic rdy, input logic rs);
    rst = rs;
    bus_a.reqs_d0 = r0; bus_a.reqs_d1 = r1; bus_a.out_rdy = rdy;
    bus_b.reqs_d0 = r0; bus_b.reqs_d1 = r1; bus_b.out_rdy = rdy;
    q_a.push_back(model(0, r0, r1, rdy, rs));
    q_b.push_back(model(1, r0, r1, rdy, rs));
    @(posedge clk);
    #1;
  endtask

  task automatic compare(input string name, input exp_t act, input exp_t exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s t=%0t: actual g0=%b g1=%b val=%b sel=%0d dom=%b, required g0=%b g1=%b val=%b sel=%0d dom=%b",
               name, $time, act.g0, act.g1, act.v, act.xs, act.cd, exp.g0, exp.g1, exp.v, exp.xs, exp.cd);
    end
  endtask

  initial begin : monitor
    exp_t act;
    forever begin
      @(negedge clk);
      if (q_a.size() > 0) begin
        act = '{g0: bus_a.grants_d0, g1: bus_a.grants_d1, v: bus_a.out_val,
                xs: bus_a.xbar_sel, cd: bus_a.cur_domain};
        compare("dut_a", act, q_a.pop_front());
      end
      if (q_b.size() > 0) begin
        act = '{g0: bus_b.grants_d0, g1: bus_b.grants_d1, v: bus_b.out_val,
                xs: bus_b.xbar_sel, cd: bus_b.cur_domain};
        compare("dut_b", act, q_b.pop_front());
      end
    end
  end

  initial begin : stimulus
    int guard;
    bus_a.reqs_d0 = 3'b000; bus_a.reqs_d1 = 3'b000; bus_a.out_rdy = 1'b0;
    bus_b.reqs_d0 = 3'b000; bus_b.reqs_d1 = 3'b000; bus_b.out_rdy = 1'b0;
    @(posedge clk); #1;
    repeat (3) step(3'b111, 3'b111, 1'b1, 1'b1);
    // Idle schedule, two full periods
    repeat (40) step(3'b000, 3'b000, 1'b1, 1'b0);
    // Domain 0 saturated; round robin resumes across periods
    repeat (60) step(3'b111, 3'b000, 1'b1, 1'b0);
    // Domain 1 held on one requester
    repeat (40) step(3'b000, 3'b010, 1'b1, 1'b0);
    // Downstream stalled for whole periods
    repeat (40) step(3'b101, 3'b000, 1'b0, 1'b0);
    repeat (20) step(3'b101, 3'b000, 1'b1, 1'b0);
    // Reset pulsed in cycle 3 of SLOT1 of the default instance
    step(3'b000, 3'b000, 1'b1, 1'b1);
    guard = 0;
    while (t_m[0] != 12 && guard < 100) begin
      step(3'b111, 3'b111, 1'b1, 1'b0);
      guard++;
    end
    step(3'b111, 3'b111, 1'b1, 1'b1);
    repeat (30) step(3'b111, 3'b111, 1'b1, 1'b0);
    // Random traffic with occasional resets
    for (int n = 0; n < 600; n++)
      step(3'($urandom), 3'($urandom), 1'($urandom_range(0, 3) != 0),
           1'($urandom_range(0, 99) == 0));
    stim_done = 1;
  end

  initial begin : finisher
    int limit;
    limit = 0;
    while (!stim_done && limit < 5000) begin
      @(posedge clk);
      limit++;
    end
    @(posedge clk);
    @(posedge clk);
    n_checks++;
    if (!stim_done || q_a.size() != 0 || q_b.size() != 0) begin
      n_fails++;
      $display("FAIL completion: actual done=%0d pending=%0d/%0d, required done=1 pending=0/0",
               stim_done, q_a.size(), q_b.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/plab4_net_tdm_output_sched.md
PLAB4_NET_TDM_OUTPUT_SCHED -- requirements
Module: plab4_net_TdmOutputSched

Interface
REQ-001 SHALL have parameter p_slot_len, default 8, meaning cycles per domain slot; legal range 1..255.
REQ-002 SHALL have parameter p_dead_len, default 2, meaning dead (drain) cycles after each slot; legal range 1..255.
REQ-003 SHALL have port clk  input  1  clock; label L.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset; label L.
REQ-005 SHALL have port reqs_d0  input  3  domain-0 requests {east, west, terminal} = bits {2,1,0}; label Domain 0.
REQ-006 SHALL have port reqs_d1  input  3  domain-1 requests, same bit mapping; label Domain 1.
REQ-007 SHALL have port out_rdy  input  1  downstream ready for the shared output port; label Domain cur_domain.
REQ-008 SHALL have port grants_d0  output  3  one-hot grant to domain-0 requester; label Domain 0.
REQ-009 SHALL have port grants_d1  output  3  one-hot grant to domain-1 requester; label Domain 1.
REQ-010 SHALL have port out_val  output  1  output port carries a flit this cycle; label Domain cur_domain.
REQ-011 SHALL have port xbar_sel  output  2  crossbar select, 0/1/2 for bit 0/1/2; label Domain cur_domain.
REQ-012 SHALL have port cur_domain  output  1  domain owning the port this cycle; label L.

Function
REQ-013 SHALL implement a 4-state FSM: SLOT0 -> DEAD0 -> SLOT1 -> DEAD1 -> SLOT0, no other transitions.
REQ-014 SHALL remain in SLOTx for exactly p_slot_len cycles and in DEADx for exactly p_dead_len cycles, using one down-counter reloaded on each state entry.
REQ-015 SHALL sequence the FSM from the timer alone; reqs_d0, reqs_d1 and out_rdy SHALL NOT affect state or counter (no slot stealing, no early end).
REQ-016 SHALL drive cur_domain = 0 in SLOT0 and DEAD0, = 1 in SLOT1 and DEAD1.
REQ-017 SHALL issue grants only in SLOTx to domain x, only when out_rdy = 1 and reqs_dx != 0; grants_d(1-x) SHALL be 0 in that cycle.
REQ-018 SHALL drive all grants to 0 and out_val to 0 in DEAD0 and DEAD1, regardless of requests or out_rdy.
REQ-019 SHALL select within a domain by round robin using a separate 3-bit one-hot priority pointer per domain.
REQ-020 SHALL grant the first asserted request at or after the pointer position, wrapping 2 -> 0.
REQ-021 SHALL, on a grant to index i in domain x, set domain x's pointer to (i+1) mod 3 on the next edge; no grant SHALL leave the pointer unchanged.
REQ-022 SHALL never update the pointer of the non-owning domain.
REQ-023 SHALL assert out_val = 1 exactly when either grant vector is nonzero.
REQ-024 SHALL drive xbar_sel = 0 for grant 3'b001, 1 for 3'b010, and 2 otherwise (including no grant), from the active domain's grant.
REQ-025 SHALL compute grants, out_val and xbar_sel combinationally from current state, pointer, reqs and out_rdy (zero latency).
REQ-026 SHALL allow a grant on the last cycle of a slot; the following DEAD cycle provides the drain interval.
REQ-027 SHALL treat a request withdrawn mid-slot as absent that cycle, with no state retained.
REQ-028 SHALL ensure at most one grant bit is set across both vectors in any cycle.

Reset
REQ-029 SHALL, while reset = 1, force the FSM to SLOT0, the counter to p_slot_len, and both pointers to 3'b001 (bit 0 highest).
REQ-030 SHALL, during reset, drive grants_d0 = grants_d1 = 0, out_val = 0, xbar_sel = 2, cur_domain = 0.
REQ-031 SHALL, on reset asserted mid-slot or mid-dead, abandon the schedule and restart from the REQ-029 state on the first cycle after deassertion.

Verification
REQ-032 SHALL cover: defaults, no requests -> cur_domain 0 for 8 cycles, 0 for 2, 1 for 8, 1 for 2, period 20, out_val always 0.
REQ-033 SHALL cover: reqs_d0 = 3'b111 held, out_rdy = 1 -> SLOT0 grants 001, 010, 100, 001, ... (xbar_sel 0, 1, 2, 0), zero grants in DEAD0/SLOT1/DEAD1, sequence resuming at the saved pointer in the next SLOT0.
REQ-034 SHALL cover: reqs_d1 = 3'b010 held during SLOT0 -> grants_d1 = 0 and domain-1 pointer unchanged; grants_d1 = 010 every SLOT1 cycle.
REQ-035 SHALL cover: out_rdy = 0 for a whole SLOT0 with reqs_d0 = 3'b101 -> no grants, pointer stays 001, slot still ends after 8 cycles.
REQ-036 SHALL cover: reset pulsed in cycle 3 of SLOT1 -> next cycle SLOT0 with counter at p_slot_len, pointers 001, and first domain-0 grant to bit 0.
REQ-037 SHALL cover: p_slot_len = 1, p_dead_len = 1 -> cur_domain toggles every 2 cycles, with at most one grant per slot.
